// File: rtl/and_stim_gen.sv
// rtl/and_stim_gen.sv - exhaustive 3-input stimulus sweep with d_in self-check
// Optional comparator/error counter enabled by macro SELF_CHECK_EN.
module and_stim_gen #(
  parameter int unsigned DWELL = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       d_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic [3:0] err_cnt,
  output logic       pass
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] vec_idx_q, vec_idx_d;
  logic [7:0] dwell_q, dwell_d;
  logic [2:0] abc_q, abc_d;
  logic       sample;
  logic       launch;

  assign sample = (state_q == DRIVE) && (dwell_q == 8'(DWELL - 1));
  assign launch = ((state_q == IDLE) || (state_q == DONE)) && start;

  always_comb begin
    state_d   = state_q;
    vec_idx_d = vec_idx_q;
    dwell_d   = dwell_q;
    abc_d     = abc_q;
    case (state_q)
      IDLE, DONE: begin
        abc_d = 3'b000;
        if (start) begin
          state_d   = DRIVE;
          vec_idx_d = 3'd0;
          dwell_d   = 8'd0;
        end
      end
      DRIVE: begin
        dwell_d = dwell_q + 8'd1;
        if (sample) begin
          dwell_d = 8'd0;
          // vector 7 always ends the sweep; vec_idx is left at 7 for inspection
          if (vec_idx_q == 3'd7) begin
            state_d = DONE;
            abc_d   = 3'b000;
          end else begin
            vec_idx_d = vec_idx_q + 3'd1;
            abc_d     = vec_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        vec_idx_d = 3'd0;
        dwell_d   = 8'd0;
        abc_d     = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_idx_q <= 3'd0;
      dwell_q   <= 8'd0;
      abc_q     <= 3'b000;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      dwell_q   <= dwell_d;
      abc_q     <= abc_d;
    end
  end

`ifdef SELF_CHECK_EN
  logic [3:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (launch) begin
      err_d = 4'd0;
    end else if (sample && (d_in != (&abc_q)) && (err_q != 4'd8)) begin
      err_d = err_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 4'd0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`else
  logic unused_d_in;
  logic unused_launch;
  assign unused_d_in   = d_in;
  assign unused_launch = launch;
  assign err_cnt       = 4'd0;
`endif

  assign {a, b, c} = abc_q;
  assign vec_idx   = vec_idx_q;
  assign busy      = (state_q == DRIVE);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_cnt == 4'd0);

endmodule
